// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 5209;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with a parameterized reset value
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic synced
);

    logic s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= RESET_VAL;
            synced <= RESET_VAL;
        end else begin
            s1     <= raw;
            synced <= s1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing-error strobe
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_t             state;
    rx_state_t             state_next;
    logic [CW-1:0]         cnt;
    logic [2:0]            bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  rx_s;
    logic                  half_done;
    logic                  bit_done;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .raw    (RxD),
        .synced (rx_s)
    );

    assign half_done = (cnt == HALF_LAST);
    assign bit_done  = (cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (!rx_s) state_next = RX_START;
            // A start bit that is high again at mid-bit was only a glitch.
            RX_START: if (half_done) state_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_done && bit_cnt == LAST_BIT) state_next = RX_STOP;
            RX_STOP:  if (bit_done) state_next = rx_s ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (rx_s) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            data          <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            framing_error <= 1'b0;

            if (state_next != state || (state == RX_DATA && bit_done)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (state == RX_START && state_next == RX_DATA) begin
                bit_cnt <= '0;
            end

            if (state == RX_DATA && bit_done) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

            // Bad stop bit leaves the previous good byte on data.
            if (state == RX_STOP && bit_done) begin
                if (rx_s) begin
                    data       <= shreg;
                    data_valid <= 1'b1;
                end else begin
                    framing_error <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy = (state != RX_IDLE);
    end

endmodule
